// File: rtl/dc_rr_arbiter_pkg.sv
// Shared helpers for the decoupled-channel arbiter family.
//   idx_width   : bits needed to index n requesters (minimum 1)
//   rr_next_ptr : round-robin successor of a granted index, modulo n
package dc_rr_arbiter_pkg;

    // Smallest w >= 1 with 2**w >= n
    function automatic int unsigned idx_width(input int unsigned n);
        int unsigned w;
        w = 32'd1;
        while ((32'd1 << w) < n) begin
            w = w + 32'd1;
        end
        return w;
    endfunction

    // Next search start after granting cur; wraps to 0 for any n, not only powers of two
    function automatic int unsigned rr_next_ptr(input int unsigned cur, input int unsigned n);
        return ((cur + 32'd1) >= n) ? 32'd0 : (cur + 32'd1);
    endfunction

endpackage

// File: rtl/dc_rr_pick.sv
// Combinational round-robin priority search.
// Ports:
//   valid_i : per-requester valid
//   ptr_i   : index where the search starts (always < N)
//   grant_o : one-hot winner (all zero when nothing is valid)
//   idx_o   : binary winner index (0 when nothing is valid)
//   any_o   : at least one requester is valid
module dc_rr_pick #(
    parameter int N  = 4,
    parameter int IW = 2
) (
    input  logic [N-1:0]  valid_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  grant_o,
    output logic [IW-1:0] idx_o,
    output logic          any_o
);

    int   pos_s;
    logic hit_s;
    logic found_s;

    // Walk N positions starting at ptr_i; the first valid one wins
    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found_s = 1'b0;
        pos_s   = 0;
        hit_s   = 1'b0;
        for (int k = 0; k < N; k++) begin
            pos_s          = (int'(ptr_i) + k) % N;
            hit_s          = !found_s && valid_i[pos_s];
            grant_o[pos_s] = grant_o[pos_s] | hit_s;
            idx_o          = hit_s ? IW'(pos_s) : idx_o;
            found_s        = found_s | hit_s;
        end
        any_o = found_s;
    end

endmodule

// File: rtl/dc_rr_arbiter.sv
// Round-robin arbiter merging INPUTS decoupled channels into one registered
// output slot with full throughput (consume and accept in the same cycle).
// Ports:
//   clock, reset        : clock, asynchronous active-low reset
//   io_c_valid/ready    : per-requester handshake
//   io_c_bits           : requester i payload at [i*WIDTH +: WIDTH]
//   io_p_valid/ready    : output handshake (valid = slot full)
//   io_p_bits, io_p_src : registered payload and its source index
module dc_rr_arbiter
    import dc_rr_arbiter_pkg::*;
#(
    parameter int INPUTS = 4,
    parameter int WIDTH  = 16
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic [INPUTS-1:0]               io_c_valid,
    output logic [INPUTS-1:0]               io_c_ready,
    input  logic [INPUTS*WIDTH-1:0]         io_c_bits,
    output logic                            io_p_valid,
    input  logic                            io_p_ready,
    output logic [WIDTH-1:0]                io_p_bits,
    output logic [idx_width(INPUTS)-1:0]    io_p_src
);

    localparam int IW = idx_width(INPUTS);

    logic              full_q, full_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [IW-1:0]     src_q,  src_d;
    logic [IW-1:0]     ptr_q,  ptr_d;

    logic              load_s;
    logic [INPUTS-1:0] grant_s;
    logic [IW-1:0]     idx_s;
    logic              any_s;
    logic [WIDTH-1:0]  sel_bits_s;

    dc_rr_pick #(
        .N  (INPUTS),
        .IW (IW)
    ) u_pick (
        .valid_i (io_c_valid),
        .ptr_i   (ptr_q),
        .grant_o (grant_s),
        .idx_o   (idx_s),
        .any_o   (any_s)
    );

    // The slot can take a new item when empty or when it drains this cycle
    assign load_s     = !full_q || io_p_ready;
    assign sel_bits_s = io_c_bits[idx_s*WIDTH +: WIDTH];

    // Grant only while out of reset so nothing is acknowledged during reset
    always_comb begin
        if (reset && load_s) begin
            io_c_ready = grant_s;
        end else begin
            io_c_ready = '0;
        end
    end

    // Next state of the output slot and round-robin pointer
    always_comb begin
        full_d = full_q;
        data_d = data_q;
        src_d  = src_q;
        ptr_d  = ptr_q;
        if (load_s) begin
            if (any_s) begin
                full_d = 1'b1;
                data_d = sel_bits_s;
                src_d  = idx_s;
                ptr_d  = IW'(rr_next_ptr(int'(idx_s), INPUTS));
            end else begin
                full_d = 1'b0;
            end
        end else begin
            full_d = full_q;
        end
    end

    // State registers; reset discards any held item
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            full_q <= 1'b0;
            data_q <= '0;
            src_q  <= '0;
            ptr_q  <= '0;
        end else begin
            full_q <= full_d;
            data_q <= data_d;
            src_q  <= src_d;
            ptr_q  <= ptr_d;
        end
    end

    assign io_p_valid = full_q;
    assign io_p_bits  = data_q;
    assign io_p_src   = src_q;

endmodule

// File: tb/tb_dc_rr_arbiter.sv
module tb_dc_rr_arbiter;

    localparam int N  = 4;
    localparam int W  = 16;
    localparam int IW = 2;

    logic clock = 1'b0;
    always #5 clock = ~clock;

    logic           reset;
    logic [N-1:0]   c_valid, c_ready;
    logic [N*W-1:0] c_bits;
    logic           p_valid, p_ready;
    logic [W-1:0]   p_bits;
    logic [IW-1:0]  p_src;

    dc_rr_arbiter #(.INPUTS(N), .WIDTH(W)) dut (
        .clock      (clock),
        .reset      (reset),
        .io_c_valid (c_valid),
        .io_c_ready (c_ready),
        .io_c_bits  (c_bits),
        .io_p_valid (p_valid),
        .io_p_ready (p_ready),
        .io_p_bits  (p_bits),
        .io_p_src   (p_src)
    );

    // Three-input instance for the non-power-of-two wrap
    logic        reset3;
    logic [2:0]  v3, r3;
    logic [23:0] b3;
    logic        pv3, pr3;
    logic [7:0]  pb3;
    logic [1:0]  ps3;

    dc_rr_arbiter #(.INPUTS(3), .WIDTH(8)) dut3 (
        .clock      (clock),
        .reset      (reset3),
        .io_c_valid (v3),
        .io_c_ready (r3),
        .io_c_bits  (b3),
        .io_p_valid (pv3),
        .io_p_ready (pr3),
        .io_p_bits  (pb3),
        .io_p_src   (ps3)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: slot contents, search pointer, per-channel sent queues
    bit           m_full;
    logic [W-1:0] m_data;
    int           m_src;
    int           m_ptr;
    logic [W-1:0] sent [N][$];
    int           wait_cnt [N];
    int           max_wait;
    logic [N-1:0] last_acc;

    task automatic model_reset();
        m_full = 1'b0;
        m_data = '0;
        m_src  = 0;
        m_ptr  = 0;
        for (int i = 0; i < N; i++) begin
            sent[i].delete();
            wait_cnt[i] = 0;
        end
    endtask

    function automatic int model_pick(input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(m_ptr + k) % N]) return (m_ptr + k) % N;
        end
        return -1;
    endfunction

    // One cycle: inputs already driven; check, update model, advance past the edge
    task automatic step(input string tag);
        int           w;
        bit           load;
        logic [N-1:0] er;
        logic [W-1:0] e;
        #1;
        load = !m_full || p_ready;
        w    = load ? model_pick(c_valid) : -1;
        er   = '0;
        if (w >= 0) er[w] = 1'b1;
        check_eq({tag, "_ready"}, 32'(c_ready), 32'(er));
        check_eq({tag, "_pvalid"}, 32'(p_valid), 32'(m_full));
        if (m_full) begin
            check_eq({tag, "_pbits"}, 32'(p_bits), 32'(m_data));
            check_eq({tag, "_psrc"}, 32'(p_src), 32'(m_src));
            if (p_ready) begin
                if (sent[m_src].size() > 0) e = sent[m_src].pop_front();
                else e = 'x;
                check_eq({tag, "_seq"}, 32'(p_bits), 32'(e));
            end
        end
        last_acc = c_valid & c_ready;
        for (int i = 0; i < N; i++) begin
            if (!c_valid[i] || last_acc[i]) wait_cnt[i] = 0;
            else if (last_acc != '0) wait_cnt[i]++;
            if (wait_cnt[i] > max_wait) max_wait = wait_cnt[i];
        end
        if (load) begin
            if (w >= 0) begin
                m_full = 1'b1;
                m_data = c_bits[w*W +: W];
                m_src  = w;
                m_ptr  = (w + 1) % N;
                sent[w].push_back(m_data);
            end else begin
                m_full = 1'b0;
            end
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [2:0] exp3 [4];
        logic [1:0] src3 [4];
        reset   = 1'b0;
        reset3  = 1'b0;
        c_valid = '0;
        c_bits  = '0;
        p_ready = 1'b0;
        v3      = '0;
        b3      = '0;
        pr3     = 1'b0;
        max_wait = 0;
        last_acc = '0;
        model_reset();
        repeat (2) @(posedge clock);
        #1;
        c_valid = 4'hF;
        #1;
        check_eq("rst_ready",  32'(c_ready), 32'd0);
        check_eq("rst_pvalid", 32'(p_valid), 32'd0);
        check_eq("rst_pbits",  32'(p_bits),  32'd0);
        check_eq("rst_psrc",   32'(p_src),   32'd0);
        reset = 1'b1;

        // All channels valid: sources rotate 0,1,2,3,0...
        p_ready = 1'b1;
        for (int i = 0; i < N; i++) c_bits[i*W +: W] = 16'h1000 + 16'(i);
        for (int k = 0; k < 8; k++) begin
            step("s030");
            check_eq("s030_src",  32'(p_src),  32'(k % N));
            check_eq("s030_bits", 32'(p_bits), 32'(16'h1000 + 16'(k % N)));
        end

        // Only channel 2 valid: accepted every cycle
        c_valid = 4'b0100;
        c_bits[2*W +: W] = 16'hBEEF;
        for (int k = 0; k < 6; k++) begin
            step("s031");
            check_eq("s031_src", 32'(p_src), 32'd2);
        end

        // Held item with downstream stalled
        c_valid = 4'hF;
        for (int i = 0; i < N; i++) c_bits[i*W +: W] = 16'h00AA;
        step("s032_load");
        p_ready = 1'b0;
        for (int k = 0; k < 5; k++) begin
            step("s032");
            check_eq("s032_hold", 32'(p_bits), 32'h00AA);
        end
        p_ready = 1'b1;
        step("s032_rel");

        // Asynchronous reset while the slot is full
        reset = 1'b0;
        #1;
        check_eq("s034_pvalid", 32'(p_valid), 32'd0);
        check_eq("s034_pbits",  32'(p_bits),  32'd0);
        check_eq("s034_ready",  32'(c_ready), 32'd0);
        model_reset();
        @(negedge clock);
        reset   = 1'b1;
        c_valid = 4'b0110;
        step("s034");
        check_eq("s034_first", 32'(p_src), 32'd1);

        // INPUTS=3, channels 0 and 2: grants alternate across the 2->0 wrap
        reset3 = 1'b1;
        v3  = 3'b101;
        b3  = {8'h22, 8'h11, 8'h00};
        pr3 = 1'b1;
        exp3[0] = 3'b001; exp3[1] = 3'b100; exp3[2] = 3'b001; exp3[3] = 3'b100;
        src3[0] = 2'd0;   src3[1] = 2'd2;   src3[2] = 2'd0;   src3[3] = 2'd2;
        for (int k = 0; k < 4; k++) begin
            #1;
            check_eq("s033_ready", 32'(r3), 32'(exp3[k]));
            @(posedge clock);
            #1;
            check_eq("s033_src", 32'(ps3), 32'(src3[k]));
        end
        v3 = '0;

        // Random traffic: valid held until accepted, payload stable while waiting
        c_valid  = '0;
        last_acc = '0;
        max_wait = 0;
        for (int i = 0; i < N; i++) wait_cnt[i] = 0;
        for (int c = 0; c < 10000; c++) begin
            for (int i = 0; i < N; i++) begin
                if (!c_valid[i] || last_acc[i]) begin
                    c_valid[i] = ($urandom_range(0, 99) < 60);
                    c_bits[i*W +: W] = W'($urandom);
                end
            end
            p_ready = ($urandom_range(0, 99) < 70);
            step("rnd");
        end
        c_valid = '0;
        p_ready = 1'b1;
        repeat (3) step("drain");
        check_eq("starve", 32'(max_wait <= N - 1), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
